selector_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the 8-bit SELECTOR 2:1 datapath. It grants the shared selector to requester B or requester C and drives the selector's select line from its grant state. It registers the selected word with a valid strobe. Fairness is round-robin with a bounded burst length, so neither requester can hold the path indefinitely while the other waits.

---
 rtl/selector_arbiter_pkg.sv | 18 +
 rtl/selector_arbiter_selector.sv | 13 +
 rtl/selector_arbiter.sv | 123 ++++++++++++
 tb/tb_selector_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/selector_arbiter_pkg.sv
// Shared types and constants for the selector arbiter: FSM state encoding,
// grant side encoding and the burst counter width.
package selector_arbiter_pkg;

  localparam int unsigned CntWidth = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGrantB = 2'd1,
    StGrantC = 2'd2
  } state_e;

  typedef enum logic {
    SideC = 1'b0,
    SideB = 1'b1
  } side_e;

endpackage

// File: rtl/selector_arbiter_selector.sv
// SELECTOR 2:1 datapath: a_i=1 routes b_i, a_i=0 routes c_i.
module selector_arbiter_selector #(
  parameter int unsigned WIDTH = 8
) (
  output logic [WIDTH-1:0] f_o,
  input  logic             a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i
);

  assign f_o = a_i ? b_i : c_i;

endmodule

// File: rtl/selector_arbiter.sv
// Round-robin arbiter with bounded bursts between requesters B and C, driving
// the shared selector and registering the selected word with a valid strobe.
module selector_arbiter
  import selector_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_B,
  input  logic             REQ_C,
  input  logic [WIDTH-1:0] B_IN,
  input  logic [WIDTH-1:0] C_IN,
  output logic             GNT_B,
  output logic             GNT_C,
  output logic             SEL,
  output logic [WIDTH-1:0] F_OUT,
  output logic             VALID_OUT
);

  localparam logic [CntWidth-1:0] BurstLast = CntWidth'(MAX_BURST - 1);

  state_e              state_q, state_d;
  side_e               last_q, last_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                sel_q, sel_d;
  logic [WIDTH-1:0]    f_q;
  logic                valid_q;
  logic [WIDTH-1:0]    sel_data;
  logic                xfer;

  selector_arbiter_selector #(
    .WIDTH (WIDTH)
  ) u_selector (
    .f_o (sel_data),
    .a_i (sel_q),
    .b_i (B_IN),
    .c_i (C_IN)
  );

  assign xfer = ((state_q == StGrantB) && REQ_B) || ((state_q == StGrantC) && REQ_C);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = '0;
    sel_d   = sel_q;
    unique case (state_q)
      StIdle: begin
        if (REQ_B && REQ_C) begin
          state_d = (last_q == SideC) ? StGrantB : StGrantC;
        end else if (REQ_B) begin
          state_d = StGrantB;
        end else if (REQ_C) begin
          state_d = StGrantC;
        end
      end
      StGrantB: begin
        if (!REQ_B) begin
          state_d = REQ_C ? StGrantC : StIdle;
        end else if ((cnt_q == BurstLast) && REQ_C) begin
          state_d = StGrantC;
        end else begin
          // Uncontested burst limit wraps the counter and keeps the grant.
          cnt_d = (cnt_q == BurstLast) ? '0 : cnt_q + 1'b1;
        end
      end
      StGrantC: begin
        if (!REQ_C) begin
          state_d = REQ_B ? StGrantB : StIdle;
        end else if ((cnt_q == BurstLast) && REQ_B) begin
          state_d = StGrantB;
        end else begin
          cnt_d = (cnt_q == BurstLast) ? '0 : cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_d == StGrantB) begin
        last_d = SideB;
      end else if (state_d == StGrantC) begin
        last_d = SideC;
      end
    end

    if (state_d == StGrantB) begin
      sel_d = 1'b1;
    end else if (state_d == StGrantC) begin
      sel_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      last_q  <= SideC;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      f_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      valid_q <= xfer;
      if (xfer) begin
        f_q <= sel_data;
      end
    end
  end

  assign GNT_B     = (state_q == StGrantB);
  assign GNT_C     = (state_q == StGrantC);
  assign SEL       = sel_q;
  assign F_OUT     = f_q;
  assign VALID_OUT = valid_q;

endmodule

// File: tb/tb_selector_arbiter.sv
// Self-checking bench for selector_arbiter: directed scenarios plus random
// traffic against a cycle-level reference model, for MAX_BURST of 4 and 1.
module tb_selector_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       REQ_B = 1'b0;
  logic       REQ_C = 1'b0;
  logic [7:0] B_IN = 8'h00;
  logic [7:0] C_IN = 8'h00;

  logic [1:0] gnt_b, gnt_c, sel, valid;
  logic [7:0] f_out4, f_out1;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state per instance (0: MAX_BURST=4, 1: MAX_BURST=1).
  // owner: 0 none, 1 B, 2 C. held: cycles spent in the current grant.
  int       m_owner [2];
  int       m_last  [2];
  int       m_held  [2];
  logic     m_sel   [2];
  logic [7:0] m_f   [2];
  logic     m_valid [2];

  selector_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .CLK(CLK), .RST(RST), .REQ_B(REQ_B), .REQ_C(REQ_C), .B_IN(B_IN), .C_IN(C_IN),
    .GNT_B(gnt_b[0]), .GNT_C(gnt_c[0]), .SEL(sel[0]), .F_OUT(f_out4),
    .VALID_OUT(valid[0])
  );

  selector_arbiter #(.WIDTH(8), .MAX_BURST(1)) dut1 (
    .CLK(CLK), .RST(RST), .REQ_B(REQ_B), .REQ_C(REQ_C), .B_IN(B_IN), .C_IN(C_IN),
    .GNT_B(gnt_b[1]), .GNT_C(gnt_c[1]), .SEL(sel[1]), .F_OUT(f_out1),
    .VALID_OUT(valid[1])
  );

  always #5 CLK = ~CLK;

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int  mb;
      int  nxt;
      int  other;
      logic own_req, oth_req;
      mb = (i == 0) ? 4 : 1;
      if (RST) begin
        m_owner[i] = 0; m_last[i] = 2; m_held[i] = 0;
        m_sel[i] = 1'b0; m_f[i] = 8'h00; m_valid[i] = 1'b0;
      end else begin
        own_req = (m_owner[i] == 1) ? REQ_B : REQ_C;
        oth_req = (m_owner[i] == 1) ? REQ_C : REQ_B;
        other   = (m_owner[i] == 1) ? 2 : 1;
        if (m_owner[i] != 0 && own_req) begin
          m_f[i] = (m_owner[i] == 1) ? B_IN : C_IN;
          m_valid[i] = 1'b1;
        end else begin
          m_valid[i] = 1'b0;
        end
        if (m_owner[i] == 0) begin
          if (REQ_B && REQ_C) nxt = (m_last[i] == 2) ? 1 : 2;
          else if (REQ_B)     nxt = 1;
          else if (REQ_C)     nxt = 2;
          else                nxt = 0;
        end else if (!own_req) begin
          nxt = oth_req ? other : 0;
        end else if ((m_held[i] % mb) == mb - 1 && oth_req) begin
          nxt = other;
        end else begin
          nxt = m_owner[i];
        end
        if (nxt != 0 && nxt == m_owner[i]) begin
          m_held[i]++;
        end else begin
          m_held[i] = 0;
          if (nxt != 0) m_last[i] = nxt;
        end
        if (nxt == 1) m_sel[i] = 1'b1;
        else if (nxt == 2) m_sel[i] = 1'b0;
        m_owner[i] = nxt;
      end
    end
  endtask

  // Advance one clock edge, update the model, and settle before sampling.
  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; REQ_B = 1'b1; REQ_C = 1'b1;
    step();
    n_cmp++;
    if ({gnt_b[0], gnt_c[0], sel[0], valid[0], f_out4} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_outputs: got gnt_b=%b gnt_c=%b sel=%b valid=%b f=%h, want all 0",
               gnt_b[0], gnt_c[0], sel[0], valid[0], f_out4);
    end
    RST = 1'b0; REQ_B = 1'b0; REQ_C = 1'b0;
  endtask

  task automatic test_single_b();
    RST = 1'b1; step(); RST = 1'b0;
    REQ_B = 1'b1; B_IN = 8'h40;
    step();
    n_cmp++;
    if (gnt_b[0] !== 1'b1 || sel[0] !== 1'b1 || gnt_c[0] !== 1'b0) begin
      n_err++;
      $display("FAIL single_b_grant: got gnt_b=%b sel=%b gnt_c=%b, want 1 1 0",
               gnt_b[0], sel[0], gnt_c[0]);
    end
    step();
    n_cmp++;
    if (f_out4 !== 8'h40 || valid[0] !== 1'b1) begin
      n_err++;
      $display("FAIL single_b_data: got f=%h valid=%b, want 40 1", f_out4, valid[0]);
    end
    REQ_B = 1'b0;
  endtask

  task automatic test_burst();
    RST = 1'b1; step(); RST = 1'b0;
    REQ_B = 1'b1; REQ_C = 1'b1;
    for (int k = 0; k < 16; k++) begin
      logic want_b;
      step();
      want_b = ((k / 4) % 2) == 0;
      n_cmp++;
      if (gnt_b[0] !== want_b || gnt_c[0] !== !want_b) begin
        n_err++;
        $display("FAIL burst4_cycle%0d: got gnt_b=%b gnt_c=%b, want %b %b",
                 k, gnt_b[0], gnt_c[0], want_b, !want_b);
      end
    end
    REQ_B = 1'b0; REQ_C = 1'b0;
  endtask

  task automatic test_c_stream();
    RST = 1'b1; step(); RST = 1'b0;
    REQ_C = 1'b1; C_IN = 8'hff;
    step();
    for (int k = 0; k < 10; k++) begin
      C_IN = 8'(k);
      step();
      n_cmp++;
      if (gnt_c[0] !== 1'b1 || f_out4 !== 8'(k) || valid[0] !== 1'b1) begin
        n_err++;
        $display("FAIL c_stream_word%0d: got gnt_c=%b f=%h valid=%b, want 1 %h 1",
                 k, gnt_c[0], f_out4, valid[0], 8'(k));
      end
    end
    REQ_C = 1'b0;
  endtask

  task automatic test_drop();
    RST = 1'b1; step(); RST = 1'b0;
    REQ_B = 1'b1; B_IN = 8'h11; C_IN = 8'h22;
    step();
    step();
    REQ_B = 1'b0; REQ_C = 1'b1;
    step();
    n_cmp++;
    if (gnt_c[0] !== 1'b1 || gnt_b[0] !== 1'b0 || valid[0] !== 1'b0 || f_out4 !== 8'h11) begin
      n_err++;
      $display("FAIL drop_handover: got gnt_c=%b gnt_b=%b valid=%b f=%h, want 1 0 0 11",
               gnt_c[0], gnt_b[0], valid[0], f_out4);
    end
    REQ_C = 1'b0;
  endtask

  task automatic test_reset_mid();
    RST = 1'b1; step(); RST = 1'b0;
    REQ_C = 1'b1; C_IN = 8'h5a;
    step();
    step();
    RST = 1'b1;
    step();
    n_cmp++;
    if ({gnt_b[0], gnt_c[0], sel[0], valid[0], f_out4} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_mid: got gnt_b=%b gnt_c=%b sel=%b valid=%b f=%h, want all 0",
               gnt_b[0], gnt_c[0], sel[0], valid[0], f_out4);
    end
    RST = 1'b0; REQ_B = 1'b1; REQ_C = 1'b1;
    step();
    n_cmp++;
    if (gnt_b[0] !== 1'b1 || gnt_c[0] !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_regrant: got gnt_b=%b gnt_c=%b, want 1 0", gnt_b[0], gnt_c[0]);
    end
    REQ_B = 1'b0; REQ_C = 1'b0;
  endtask

  task automatic test_burst1();
    RST = 1'b1; step(); RST = 1'b0;
    REQ_B = 1'b1; REQ_C = 1'b1; B_IN = 8'haa; C_IN = 8'h55;
    for (int k = 0; k < 8; k++) begin
      logic want_b;
      step();
      want_b = (k % 2) == 0;
      n_cmp++;
      if (gnt_b[1] !== want_b || gnt_c[1] !== !want_b) begin
        n_err++;
        $display("FAIL burst1_gnt%0d: got gnt_b=%b gnt_c=%b, want %b %b",
                 k, gnt_b[1], gnt_c[1], want_b, !want_b);
      end
      if (k > 0) begin
        logic [7:0] want_f;
        want_f = want_b ? 8'h55 : 8'haa;
        n_cmp++;
        if (f_out1 !== want_f || valid[1] !== 1'b1) begin
          n_err++;
          $display("FAIL burst1_data%0d: got f=%h valid=%b, want %h 1",
                   k, f_out1, valid[1], want_f);
        end
      end
    end
    REQ_B = 1'b0; REQ_C = 1'b0;
  endtask

  task automatic test_random();
    RST = 1'b1; step(); RST = 1'b0;
    for (int k = 0; k < 400; k++) begin
      RST   = ($urandom_range(0, 49) == 0);
      REQ_B = ($urandom_range(0, 3) != 0);
      REQ_C = ($urandom_range(0, 3) != 0);
      B_IN  = 8'($urandom);
      C_IN  = 8'($urandom);
      step();
      for (int i = 0; i < 2; i++) begin
        logic [7:0] f_act;
        f_act = (i == 0) ? f_out4 : f_out1;
        n_cmp++;
        if (gnt_b[i] !== (m_owner[i] == 1) || gnt_c[i] !== (m_owner[i] == 2) ||
            sel[i] !== m_sel[i] || valid[i] !== m_valid[i] || f_act !== m_f[i]) begin
          n_err++;
          $display("FAIL random_dut%0d_cycle%0d: got gnt_b=%b gnt_c=%b sel=%b valid=%b f=%h, want %b %b %b %b %h",
                   i, k, gnt_b[i], gnt_c[i], sel[i], valid[i], f_act,
                   m_owner[i] == 1, m_owner[i] == 2, m_sel[i], m_valid[i], m_f[i]);
        end
      end
    end
    RST = 1'b0; REQ_B = 1'b0; REQ_C = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = 0; m_last[i] = 2; m_held[i] = 0;
      m_sel[i] = 1'b0; m_f[i] = 8'h00; m_valid[i] = 1'b0;
    end
    test_reset();
    test_single_b();
    test_burst();
    test_c_stream();
    test_drop();
    test_reset_mid();
    test_burst1();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
